// File: rtl/conv_spike_sched_if.sv
// Spike input stream and shared neuron-core control bus used by conv_spike_sched.
// Stream: a spike transfers on a rising clk edge with spk_valid && spk_ready; the producer holds fields stable while spk_valid is high.
interface conv_spike_sched_spk_if #(
    parameter int CW = 5,
    parameter int IW = 3
);
    logic          spk_valid;
    logic          spk_ready;
    logic [CW-1:0] spk_y;
    logic [CW-1:0] spk_x;
    logic [IW-1:0] spk_ic;
    logic          spk_eot;

    modport master (output spk_valid, spk_y, spk_x, spk_ic, spk_eot, input spk_ready);
    modport slave  (input spk_valid, spk_y, spk_x, spk_ic, spk_eot, output spk_ready);
endinterface

interface conv_spike_sched_core_if #(
    parameter int CW = 5,
    parameter int IW = 3,
    parameter int FW = 4,
    parameter int OW = 4
);
    logic          en_accum;
    logic          en_activ;
    logic          ic_done;
    logic [IW-1:0] ic;
    logic [FW-1:0] filter_phase;
    logic [OW-1:0] oc_phase;
    logic [CW-1:0] affect_neur_addr_y;
    logic [CW-1:0] affect_neur_addr_x;
    logic          neur_addr_invalid;

    modport master (output en_accum, en_activ, ic_done, ic, filter_phase, oc_phase,
                    affect_neur_addr_y, affect_neur_addr_x, neur_addr_invalid);
    modport slave  (input en_accum, en_activ, ic_done, ic, filter_phase, oc_phase,
                    affect_neur_addr_y, affect_neur_addr_x, neur_addr_invalid);
endinterface

// File: rtl/conv_spike_sched.sv
// Event-driven conv-layer sequencer: expands input spikes into per-kernel-offset neuron addresses and runs the per-time-step activation sweep.
// Optional CONV_SCHED_BUBBLE_EN inserts one invalid cycle between consecutive spike expansions.
module conv_spike_sched #(
    parameter int IN_CHANNELS        = 2,
    parameter int OUT_CHANNELS       = 4,
    parameter int EC_SIZE            = 2,
    parameter int KERNEL_SIZE        = 3,
    parameter int INPUT_FRAME_WIDTH  = 28,
    parameter int OUTPUT_FRAME_WIDTH = 26,
    parameter int NUM_TIME_STEPS     = 25,
    parameter int ACTIV_CYCLES       = OUTPUT_FRAME_WIDTH*OUTPUT_FRAME_WIDTH+2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    conv_spike_sched_spk_if.slave   spk,
    conv_spike_sched_core_if.master core,
    output logic                    last_time_step,
    output logic                    busy,
    output logic                    done,
    output logic                    coord_err,
    output logic [2:0]              dbg_state
);
    localparam int CW        = $clog2(INPUT_FRAME_WIDTH);
    localparam int IW        = $clog2(IN_CHANNELS) + 2;
    localparam int FW        = $clog2(KERNEL_SIZE) + 2;
    localparam int OW        = $clog2(OUT_CHANNELS) + 2;
    localparam int KW        = $clog2(KERNEL_SIZE) + 1;
    localparam int OC_PHASES = OUT_CHANNELS / EC_SIZE;
    localparam int TSW       = (NUM_TIME_STEPS > 1) ? $clog2(NUM_TIME_STEPS) : 1;
    localparam int WW        = (ACTIV_CYCLES > 1) ? $clog2(ACTIV_CYCLES) : 1;

    localparam logic [KW-1:0]  K_LAST    = KW'(KERNEL_SIZE - 1);
    localparam logic [OW-1:0]  OC_LAST   = OW'(OC_PHASES - 1);
    localparam logic [TSW-1:0] TS_LAST   = TSW'(NUM_TIME_STEPS - 1);
    localparam logic [WW-1:0]  WAIT_LOAD = WW'(ACTIV_CYCLES - 1);
    localparam logic [CW:0]    IFW_LIM   = (CW+1)'(INPUT_FRAME_WIDTH);
    localparam logic [CW-1:0]  OFW_LIM   = CW'(OUTPUT_FRAME_WIDTH);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ARM        = 3'd1,
        WAIT_SPK   = 3'd2,
        ACCUM      = 3'd3,
        BUBBLE     = 3'd4,
        ACTIV      = 3'd5,
        ACTIV_WAIT = 3'd6,
        DONE       = 3'd7
    } state_t;

`ifdef CONV_SCHED_BUBBLE_EN
    localparam state_t AFTER_SPIKE = BUBBLE;
`else
    localparam state_t AFTER_SPIKE = WAIT_SPK;
`endif

    state_t         state_q, state_d;
    logic [TSW-1:0] ts_q, ts_d;
    logic [WW-1:0]  wait_q, wait_d;
    logic [CW-1:0]  y_q, y_d, x_q, x_d;
    logic [IW-1:0]  ic_q, ic_d;
    logic [OW-1:0]  oc_q, oc_d;
    logic [KW-1:0]  ky_q, ky_d, kx_q, kx_d;
    logic [FW-1:0]  fp_q, fp_d;
    logic [CW-1:0]  ay_q, ay_d, ax_q, ax_d;
    logic           inv_q, inv_d;
    logic           coord_err_q, coord_err_d;
    logic           spk_ready_q, en_accum_q, en_activ_q;
    logic           busy_q, done_q, lts_q;

    logic           spk_fire;
    logic           accum_last;
    logic           emit;
    logic [CW-1:0]  y_src, x_src;
    logic [CW:0]    dy, dx;

    // Differences are one bit wider than a coordinate, so the MSB is the sign.
    function automatic logic out_of_frame(input logic [CW:0] d);
        return d[CW] || (d[CW-1:0] >= OFW_LIM);
    endfunction

    assign spk_fire   = spk.spk_valid && spk_ready_q;
    assign accum_last = (oc_q == OC_LAST) && (ky_q == K_LAST) && (kx_q == K_LAST);

    always_comb begin
        state_d     = state_q;
        ts_d        = ts_q;
        wait_d      = wait_q;
        coord_err_d = coord_err_q;
        y_d         = y_q;
        x_d         = x_q;
        ic_d        = ic_q;
        oc_d        = oc_q;
        ky_d        = ky_q;
        kx_d        = kx_q;
        fp_d        = fp_q;
        ay_d        = ay_q;
        ax_d        = ax_q;
        inv_d       = 1'b1;
        emit        = 1'b0;
        y_src       = y_q;
        x_src       = x_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = ARM;
                    ts_d        = '0;
                    coord_err_d = 1'b0;
                end
            end
            ARM: state_d = WAIT_SPK;
            WAIT_SPK: begin
                if (spk_fire) begin
                    if (spk.spk_eot) begin
                        state_d = ACTIV;
                    end else if (({1'b0, spk.spk_y} >= IFW_LIM) || ({1'b0, spk.spk_x} >= IFW_LIM)) begin
                        coord_err_d = 1'b1;
                    end else begin
                        state_d = ACCUM;
                        y_d     = spk.spk_y;
                        x_d     = spk.spk_x;
                        ic_d    = spk.spk_ic;
                        oc_d    = '0;
                        ky_d    = '0;
                        kx_d    = '0;
                        fp_d    = '0;
                        y_src   = spk.spk_y;
                        x_src   = spk.spk_x;
                        emit    = 1'b1;
                    end
                end
            end
            ACCUM: begin
                // Output registers hold the current offset; advance to the next one.
                if (accum_last) begin
                    state_d = AFTER_SPIKE;
                end else begin
                    emit = 1'b1;
                    if (kx_q != K_LAST) begin
                        kx_d = kx_q + 1'b1;
                        fp_d = fp_q + 1'b1;
                    end else begin
                        kx_d = '0;
                        if (ky_q != K_LAST) begin
                            ky_d = ky_q + 1'b1;
                            fp_d = fp_q + 1'b1;
                        end else begin
                            ky_d = '0;
                            fp_d = '0;
                            oc_d = oc_q + 1'b1;
                        end
                    end
                end
            end
            BUBBLE: state_d = WAIT_SPK;
            ACTIV: begin
                state_d = ACTIV_WAIT;
                wait_d  = WAIT_LOAD;
            end
            ACTIV_WAIT: begin
                if (wait_q == '0) begin
                    if (ts_q == TS_LAST) begin
                        state_d = DONE;
                    end else begin
                        ts_d    = ts_q + 1'b1;
                        state_d = ARM;
                    end
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        dy = {1'b0, y_src} - (CW+1)'(ky_d);
        dx = {1'b0, x_src} - (CW+1)'(kx_d);
        if (emit) begin
            ay_d  = dy[CW-1:0];
            ax_d  = dx[CW-1:0];
            inv_d = out_of_frame(dy) || out_of_frame(dx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ts_q        <= '0;
            wait_q      <= '0;
            coord_err_q <= 1'b0;
            y_q         <= '0;
            x_q         <= '0;
            ic_q        <= '0;
            oc_q        <= '0;
            ky_q        <= '0;
            kx_q        <= '0;
            fp_q        <= '0;
            ay_q        <= '0;
            ax_q        <= '0;
            inv_q       <= 1'b1;
            spk_ready_q <= 1'b0;
            en_accum_q  <= 1'b0;
            en_activ_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            lts_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ts_q        <= ts_d;
            wait_q      <= wait_d;
            coord_err_q <= coord_err_d;
            y_q         <= y_d;
            x_q         <= x_d;
            ic_q        <= ic_d;
            oc_q        <= oc_d;
            ky_q        <= ky_d;
            kx_q        <= kx_d;
            fp_q        <= fp_d;
            ay_q        <= ay_d;
            ax_q        <= ax_d;
            inv_q       <= inv_d;
            // Strobes and status are decoded from the next state so they line up with it.
            spk_ready_q <= (state_d == WAIT_SPK);
            en_accum_q  <= (state_d == ARM);
            en_activ_q  <= (state_d == ACTIV);
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
            lts_q       <= (state_d != IDLE) && (ts_d == TS_LAST);
        end
    end

    assign spk.spk_ready           = spk_ready_q;
    assign core.en_accum           = en_accum_q;
    assign core.en_activ           = en_activ_q;
    assign core.ic_done            = en_activ_q;
    assign core.ic                 = ic_q;
    assign core.filter_phase       = fp_q;
    assign core.oc_phase           = oc_q;
    assign core.affect_neur_addr_y = ay_q;
    assign core.affect_neur_addr_x = ax_q;
    assign core.neur_addr_invalid  = inv_q;
    assign last_time_step          = lts_q;
    assign busy                    = busy_q;
    assign done                    = done_q;
    assign coord_err               = coord_err_q;
    assign dbg_state               = state_q;

endmodule

// File: tb/tb_conv_spike_sched.sv
// Directed/randomized bench for conv_spike_sched with a queue-based expansion model.
module tb_conv_spike_sched;
    localparam int IFW = 28;
    localparam int W   = 26;
    localparam int K   = 3;
    localparam int OCP = 2;
    localparam int NTS = 2;
    localparam int ACT = W*W + 2;
    localparam int CW  = 5;
    localparam int IW  = 3;
    localparam int FW  = 4;
    localparam int OW  = 4;
    localparam int SPK_CYC = OCP*K*K;
`ifdef CONV_SCHED_BUBBLE_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 0;
`endif

    typedef struct {
        int oc;
        int fp;
        int ay;
        int ax;
        bit inv;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       last_time_step, busy, done, coord_err;
    logic [2:0] dbg_state;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    exp_t       exp_q[$];

    conv_spike_sched_spk_if  #(.CW(CW), .IW(IW)) sif ();
    conv_spike_sched_core_if #(.CW(CW), .IW(IW), .FW(FW), .OW(OW)) cif ();

    conv_spike_sched #(.NUM_TIME_STEPS(NTS)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .spk            (sif),
        .core           (cif),
        .last_time_step (last_time_step),
        .busy           (busy),
        .done           (done),
        .coord_err      (coord_err),
        .dbg_state      (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected expansion order: out-channel group outer, kernel offsets in raster order inner.
    function automatic void model_spike(input int y, input int x);
        exp_t e;
        for (int oc = 0; oc < OCP; oc++)
            for (int ky = 0; ky < K; ky++)
                for (int kx = 0; kx < K; kx++) begin
                    e.oc  = oc;
                    e.fp  = ky*K + kx;
                    e.ay  = y - ky;
                    e.ax  = x - kx;
                    e.inv = (e.ay < 0) || (e.ax < 0) || (e.ay >= W) || (e.ax >= W);
                    exp_q.push_back(e);
                end
    endfunction

    task automatic check_reset(input string pfx);
        chk({pfx, "_ready"},    32'(sif.spk_ready), 0);
        chk({pfx, "_en_accum"}, 32'(cif.en_accum), 0);
        chk({pfx, "_en_activ"}, 32'(cif.en_activ), 0);
        chk({pfx, "_ic_done"},  32'(cif.ic_done), 0);
        chk({pfx, "_ic"},       32'(cif.ic), 0);
        chk({pfx, "_fp"},       32'(cif.filter_phase), 0);
        chk({pfx, "_oc"},       32'(cif.oc_phase), 0);
        chk({pfx, "_ay"},       32'(cif.affect_neur_addr_y), 0);
        chk({pfx, "_ax"},       32'(cif.affect_neur_addr_x), 0);
        chk({pfx, "_invalid"},  32'(cif.neur_addr_invalid), 1);
        chk({pfx, "_lts"},      32'(last_time_step), 0);
        chk({pfx, "_busy"},     32'(busy), 0);
        chk({pfx, "_done"},     32'(done), 0);
        chk({pfx, "_coord_err"}, 32'(coord_err), 0);
    endtask

    // Called at a negedge; returns at the negedge after the accepting cycle.
    task automatic send(input int y, input int x, input int icv, input bit eot, output int acc_cyc);
        int n;
        n = 0;
        sif.spk_valid = 1'b1;
        sif.spk_y     = CW'(y);
        sif.spk_x     = CW'(x);
        sif.spk_ic    = IW'(icv);
        sif.spk_eot   = eot;
        while (sif.spk_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("spk_ready_wait", 32'(sif.spk_ready), 1);
        acc_cyc = cyc;
        @(negedge clk);
        sif.spk_valid = 1'b0;
        sif.spk_eot   = 1'b0;
    endtask

    task automatic expand(input int y, input int x, input int icv);
        exp_t e;
        model_spike(y, x);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("oc_phase",     32'(cif.oc_phase), e.oc);
            chk("filter_phase", 32'(cif.filter_phase), e.fp);
            chk("addr_invalid", 32'(cif.neur_addr_invalid), 32'(e.inv));
            if (!e.inv) begin
                chk("addr_y", 32'(cif.affect_neur_addr_y), e.ay);
                chk("addr_x", 32'(cif.affect_neur_addr_x), e.ax);
            end
            chk("ic",           32'(cif.ic), icv);
            chk("ready_in_exp", 32'(sif.spk_ready), 0);
            @(negedge clk);
        end
        chk("post_invalid", 32'(cif.neur_addr_invalid), 1);
        chk("post_ready",   32'(sif.spk_ready), 32'(GAP == 0));
        repeat (GAP) @(negedge clk);
        chk("post_gap_ready",   32'(sif.spk_ready), 1);
        chk("post_gap_invalid", 32'(cif.neur_addr_invalid), 1);
    endtask

    // Sends end-of-step and walks the activation wait; returns at the cycle after it.
    task automatic end_step(input int exp_lts);
        int acc;
        int n_accum, n_activ, n_ready, n_lts;
        n_accum = 0; n_activ = 0; n_ready = 0; n_lts = 0;
        send(0, 0, 0, 1'b1, acc);
        chk("activ_en",       32'(cif.en_activ), 1);
        chk("activ_ic_done",  32'(cif.ic_done), 1);
        chk("activ_ready",    32'(sif.spk_ready), 0);
        chk("activ_en_accum", 32'(cif.en_accum), 0);
        repeat (ACT) begin
            @(negedge clk);
            n_accum += int'(cif.en_accum);
            n_activ += int'(cif.en_activ) + int'(cif.ic_done);
            n_ready += int'(sif.spk_ready);
            n_lts   += int'(last_time_step);
        end
        chk("wait_en_accum", n_accum, 0);
        chk("wait_en_activ", n_activ, 0);
        chk("wait_ready",    n_ready, 0);
        chk("wait_lts",      n_lts, exp_lts * ACT);
        @(negedge clk);
    endtask

    initial begin
        int acc, prev, y, x, icv;
        int ty[3] = '{5, 0, 27};
        sif.spk_valid = 1'b0;
        sif.spk_y     = '0;
        sif.spk_x     = '0;
        sif.spk_ic    = '0;
        sif.spk_eot   = 1'b0;
        prev = 0;

        @(negedge clk);
        check_reset("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy",  32'(busy), 0);
        chk("idle_ready", 32'(sif.spk_ready), 0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("arm_en_accum", 32'(cif.en_accum), 1);
        chk("arm_busy",     32'(busy), 1);
        chk("arm_lts_ts0",  32'(last_time_step), 0);
        chk("arm_ready",    32'(sif.spk_ready), 0);
        @(negedge clk);
        chk("wait_en_accum_off", 32'(cif.en_accum), 0);
        chk("wait_ready_on",     32'(sif.spk_ready), 1);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy_ignored", 32'(cif.en_accum), 0);
        chk("start_busy_ready",   32'(sif.spk_ready), 1);

        for (int i = 0; i < 7; i++) begin
            if (i < 3) begin
                y = ty[i];
                x = ty[i];
            end else begin
                y = $urandom_range(0, IFW-1);
                x = $urandom_range(0, IFW-1);
            end
            icv = $urandom_range(0, 1);
            send(y, x, icv, 1'b0, acc);
            if (i > 0) chk("b2b_gap", acc - prev, SPK_CYC + 1 + GAP);
            prev = acc;
            expand(y, x, icv);
        end

        send(3, 30, 1, 1'b0, acc);
        chk("coord_err_set",   32'(coord_err), 1);
        chk("coord_err_ready", 32'(sif.spk_ready), 1);
        chk("coord_err_inv",   32'(cif.neur_addr_invalid), 1);
        y = $urandom_range(0, IFW-1);
        x = $urandom_range(0, IFW-1);
        send(y, x, 1, 1'b0, acc);
        expand(y, x, 1);
        chk("coord_err_sticky", 32'(coord_err), 1);

        end_step(0);
        chk("ts1_arm_en_accum", 32'(cif.en_accum), 1);
        chk("ts1_lts",          32'(last_time_step), 1);
        chk("ts1_done",         32'(done), 0);
        end_step(1);
        chk("done_pulse",    32'(done), 1);
        chk("done_en_accum", 32'(cif.en_accum), 0);
        @(negedge clk);
        chk("after_done",      32'(done), 0);
        chk("after_done_busy", 32'(busy), 0);
        chk("after_done_lts",  32'(last_time_step), 0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("run2_en_accum", 32'(cif.en_accum), 1);
        chk("run2_coord_clr", 32'(coord_err), 0);
        @(negedge clk);
        send(5, 5, 1, 1'b0, acc);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("run3_en_accum", 32'(cif.en_accum), 1);
        chk("run3_busy",     32'(busy), 1);
        chk("run3_lts_ts0",  32'(last_time_step), 0);
        y = $urandom_range(0, IFW-1);
        x = $urandom_range(0, IFW-1);
        icv = $urandom_range(0, 1);
        send(y, x, icv, 1'b0, acc);
        expand(y, x, icv);
        end_step(0);
        chk("run3_ts1_arm", 32'(cif.en_accum), 1);
        chk("run3_ts1_lts", 32'(last_time_step), 1);
        chk("run3_ts1_done", 32'(done), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_spike_sched.md
# conv_spike_sched

Event-driven sequencer for one convolutional layer's neuron cores. It accepts input spike events (y, x, input channel) through a valid/ready stream and expands each spike into per-kernel-offset affected-neuron addresses, address-valid flags and filter/out-channel phases. At each end-of-time-step marker it triggers the cores' activation sweep and waits for it to finish. It sits between the layer's input spike FIFO and the bank of conv neuron cores, driving their shared control bus.

## Interface
- IN_CHANNELS, 2, input channels per layer
- OUT_CHANNELS, 4, output channels; OC_PHASES = OUT_CHANNELS/EC_SIZE
- EC_SIZE, 2, channels handled concurrently by the core bank
- KERNEL_SIZE, 3, square kernel side K
- INPUT_FRAME_WIDTH, 28, input frame side
- OUTPUT_FRAME_WIDTH, 26, output frame side W; equals INPUT_FRAME_WIDTH-K+1
- NUM_TIME_STEPS, 25, time steps per inference
- ACTIV_CYCLES, OUTPUT_FRAME_WIDTH*OUTPUT_FRAME_WIDTH+2, wait after en_activ pulse

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin an inference; sampled in IDLE only
- spk_valid  in  1  spike event valid
- spk_ready  out  1  spike accepted when valid&ready
- spk_y, spk_x  in  $clog2(INPUT_FRAME_WIDTH) each  spike coordinate
- spk_ic  in  $clog2(IN_CHANNELS)+2  spike input channel
- spk_eot  in  1  end-of-time-step marker; coordinates ignored
- en_accum, en_activ, ic_done  out  1  single-cycle core commands
- ic  out  $clog2(IN_CHANNELS)+2  channel of current spike
- filter_phase  out  $clog2(KERNEL_SIZE)+2  ky*K+kx
- oc_phase  out  $clog2(OUT_CHANNELS)+2  current out-channel group
- affect_neur_addr_y, affect_neur_addr_x  out  $clog2(INPUT_FRAME_WIDTH) each  affected neuron
- neur_addr_invalid  out  1  current address is not a real neuron
- last_time_step  out  1  high for the whole final time step
- busy, done  out  1  inference in progress / one-cycle completion pulse
- coord_err  out  1  sticky; spike coordinate ≥ INPUT_FRAME_WIDTH seen

## Operation
- States: IDLE, ARM, WAIT_SPK, ACCUM, BUBBLE, ACTIV, ACTIV_WAIT, DONE.
- IDLE: start=1 → ARM; ts←0; busy←1; coord_err←0.
- ARM: en_accum=1 for one cycle → WAIT_SPK.
- WAIT_SPK: spk_ready=1. On a handshake with spk_eot=1 → ACTIV. With spk_eot=0, latch y, x and ic. If y or x ≥ INPUT_FRAME_WIDTH, set coord_err, drop the spike and stay. Otherwise clear counters and go → ACCUM.
- ACCUM: one output per cycle. oc_phase is the outer loop over 0..OC_PHASES-1; (ky,kx) is the inner loop, raster order.
  - addr_y = y-ky, addr_x = x-kx, computed one bit wider and signed.
  - neur_addr_invalid=1 if either value is negative or ≥ W.
  - After the last (oc,ky,kx) → BUBBLE if CONV_SCHED_BUBBLE_EN is defined, else → WAIT_SPK.
- BUBBLE: one cycle with neur_addr_invalid=1 → WAIT_SPK.
- ACTIV: en_activ=1 and ic_done=1 for one cycle → ACTIV_WAIT. Load the wait counter with ACTIV_CYCLES-1.
- ACTIV_WAIT: count down to 0. Then:
  - if ts=NUM_TIME_STEPS-1 → DONE;
  - else ts←ts+1 → ARM.
- DONE: done=1 for one cycle, busy←0 → IDLE.
- last_time_step = (ts==NUM_TIME_STEPS-1) && busy.
- Outside ACCUM/BUBBLE: neur_addr_invalid=1, and the address/phase outputs hold their last values.

## Timing
- All outputs are registered. Reset values: every output 0, except neur_addr_invalid=1.
- Spike accepted in cycle n → first address at n+1; last address at n+OC_PHASES·K².
- Next spike accepted at n+OC_PHASES·K²+1 (+1 with bubble).
- spk_ready is deasserted in every state except WAIT_SPK.
- start while busy is ignored.
- spk_eot immediately after ARM (empty time step) still produces the full activation sweep.
- rst_n asserted mid-inference: immediate return to IDLE with reset output values. Any partially expanded spike is lost. The upstream stream is not rewound.
- Time step period = 1 (ARM) + spike cycles + 1 (ACTIV) + ACTIV_CYCLES.

## Configuration
- CONV_SCHED_BUBBLE_EN defined: one invalid cycle between consecutive spikes. This avoids a read-modify-write collision in the core's membrane BRAM when the last address of one spike equals the first address of the next.
- Not defined: spikes expand back-to-back. Upstream must guarantee that no address repeats across adjacent spikes.

## Test plan
- Spike (y=5, x=5, ic=0), defaults → nine addresses (5,5),(5,4),(5,3),(4,5)…(3,3) with filter_phase 0..8, all valid, for oc_phase 0, then the same for oc_phase 1; 18 cycles total.
- Spike (0,0) → only filter_phase 0 is valid; the other eight addresses have neur_addr_invalid=1. Spike (27,27) → only filter_phase 8 is valid.
- spk_eot with NUM_TIME_STEPS=2 → en_activ and ic_done each pulse once, then 678 idle cycles, then ARM/en_accum. last_time_step is high throughout ts 1. The second eot is followed by done, and busy drops.
- Two back-to-back spikes, with and without CONV_SCHED_BUBBLE_EN → the second spike's first address appears 1 cycle later when the macro is defined. spk_ready stays low during expansion.
- Spike x=30 → coord_err=1 and stays high; no ACCUM cycles are emitted; the next valid spike is processed normally.
- rst_n pulled low in ACCUM at cycle 4 → all outputs return to their reset values asynchronously. start after release runs a fresh inference from ts=0.
